clocked_edge_one_shot: RTL and testbench



---
 rtl/oneshot_pkg.sv | 15 +
 rtl/level_synchronizer.sv | 25 ++
 rtl/clocked_edge_one_shot.sv | 65 ++++++
 tb/tb_clocked_edge_one_shot.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/oneshot_pkg.sv
// Shared definitions for the clocked edge one-shot: FSM state encoding and
// the default synchronizer depth.
package oneshot_pkg;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } oneshotState_t;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;

endpackage : oneshot_pkg

// File: rtl/level_synchronizer.sv
// Parameterized flop chain that brings an asynchronous level into the clock
// domain. Every stage clears on asynchronous active-low Reset.
module level_synchronizer #(
  parameter int STAGES = oneshot_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic Reset,
  input  logic levelIn,
  output logic levelOut
);

  logic [STAGES-1:0] syncChain;

  // NOTE: every stage is reset so no stale level can fake an edge after reset.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[STAGES-2:0], levelIn};
    end
  end

  assign levelOut = syncChain[STAGES-1];

endmodule : level_synchronizer

// File: rtl/clocked_edge_one_shot.sv
// Turns a slow level (e.g. the I2C bit clock) into one-cycle rising and falling
// strobes. Define ONESHOT_SYNC_EN to put a SYNC_STAGES-deep synchronizer in front.
module clocked_edge_one_shot
  import oneshot_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic Reset,
  input  logic InputPulse,
  output logic PosOneShot,
  output logic NegOneShot
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : gBadStages
    $error("SYNC_STAGES must be in the range 2..4");
  end

  logic          sampledLevel;
  oneshotState_t state;

`ifdef ONESHOT_SYNC_EN
  level_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) uSync (
    .clock   (clock),
    .Reset   (Reset),
    .levelIn (InputPulse),
    .levelOut(sampledLevel)
  );
`else
  assign sampledLevel = InputPulse;
`endif

  // INIT absorbs the first sample so a level already high at reset release
  // does not look like a rising edge.
  // NOTE: non-blocking assignments keep state and strobes updating together.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state      <= INIT;
      PosOneShot <= 1'b0;
      NegOneShot <= 1'b0;
    end else begin
      PosOneShot <= 1'b0;
      NegOneShot <= 1'b0;
      unique case (state)
        INIT: state <= sampledLevel ? HIGH : LOW;
        LOW: begin
          if (sampledLevel) begin
            state      <= HIGH;
            PosOneShot <= 1'b1;
          end
        end
        HIGH: begin
          if (!sampledLevel) begin
            state      <= LOW;
            NegOneShot <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule : clocked_edge_one_shot

// File: tb/tb_clocked_edge_one_shot.sv
// Directed bench for clocked_edge_one_shot: vector table plus hand-written
// sequences for reset and multi-cycle behaviour.
module tb_clocked_edge_one_shot;

  logic clock = 1'b0;
  logic Reset;
  logic InputPulse;
  logic PosOneShot;
  logic NegOneShot;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  clocked_edge_one_shot #(
    .SYNC_STAGES(3)
  ) dut (
    .clock     (clock),
    .Reset     (Reset),
    .InputPulse(InputPulse),
    .PosOneShot(PosOneShot),
    .NegOneShot(NegOneShot)
  );

  typedef struct {
    logic inLevel;
    logic expPos;
    logic expNeg;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive a level at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic lvl);
    @(negedge clock);
    InputPulse = lvl;
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut(input logic lvl);
    @(negedge clock);
    Reset      = 1'b0;
    InputPulse = lvl;
    repeat (2) @(posedge clock);
    #1;
    check("reset_pos", PosOneShot, 1'b0);
    check("reset_neg", NegOneShot, 1'b0);
    @(negedge clock);
    Reset = 1'b1;
  endtask

  initial begin
    int strobes;
    Reset      = 1'b0;
    InputPulse = 1'b0;

`ifdef ONESHOT_SYNC_EN
    resetDut(1'b0);
    repeat (5) step(1'b0);
    @(posedge clock);
    #3;
    InputPulse = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("sync_pos_e%0d", k), PosOneShot, (k == 3));
      check($sformatf("sync_neg_e%0d", k), NegOneShot, 1'b0);
    end
`else
    // Input high through reset and afterwards: no strobe at all.
    resetDut(1'b1);
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      strobes += int'(PosOneShot) + int'(NegOneShot);
    end
    checkCount("high_after_reset_strobes", strobes, 0);

    vecs[0]  = '{1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0};

    resetDut(1'b0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].inLevel);
      check($sformatf("vec%0d_pos", i), PosOneShot, vecs[i].expPos);
      check($sformatf("vec%0d_neg", i), NegOneShot, vecs[i].expNeg);
    end

    // Rise held 20 cycles, then fall: one strobe each.
    step(1'b1);
    check("hold_rise_pos", PosOneShot, 1'b1);
    check("hold_rise_neg", NegOneShot, 1'b0);
    strobes = 0;
    for (int k = 0; k < 19; k++) begin
      step(1'b1);
      strobes += int'(PosOneShot) + int'(NegOneShot);
    end
    checkCount("hold_high_extra_strobes", strobes, 0);
    step(1'b0);
    check("fall_neg", NegOneShot, 1'b1);
    check("fall_pos", PosOneShot, 1'b0);
    step(1'b0);
    check("fall_after_neg", NegOneShot, 1'b0);

    // Toggle every cycle: alternating strobes, eight in total.
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      step(k[0] ? 1'b0 : 1'b1);
      check($sformatf("toggle%0d_pos", k), PosOneShot, !k[0]);
      check($sformatf("toggle%0d_neg", k), NegOneShot, k[0]);
      check($sformatf("toggle%0d_excl", k), PosOneShot & NegOneShot, 1'b0);
      strobes += int'(PosOneShot) + int'(NegOneShot);
    end
    checkCount("toggle_strobes", strobes, 8);

    // Reset asserted mid-strobe clears outputs asynchronously.
    step(1'b1);
    check("midreset_pre_pos", PosOneShot, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset_pos", PosOneShot, 1'b0);
    check("midreset_neg", NegOneShot, 1'b0);
    @(negedge clock);
    Reset = 1'b1;
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      strobes += int'(PosOneShot) + int'(NegOneShot);
    end
    checkCount("post_reset_spurious", strobes, 0);
    step(1'b0);
    check("post_reset_neg", NegOneShot, 1'b1);
    check("post_reset_pos", PosOneShot, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule : tb_clocked_edge_one_shot
